multicycle_controller: RTL

- Multi-cycle successor to the single-cycle RV32I main decoder. A state machine sequences fetch, decode, execute, memory and writeback over several cycles, and handshakes with a single shared instruction/data memory port.
- Drives datapath mux selects, write enables, ALU control and shift mode per state.
- Keeps a retired-instruction counter.
- Sits between the instruction register and the shared-memory datapath.

---
 rtl/multicycle_controller_if.sv | 10 +
 rtl/multicycle_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake between the multi-cycle controller and the memory port.
interface multicycle_controller_if;
    logic mem_req_o;
    logic mem_we_o;
    logic iord_o;
    logic mem_ready_i;

    modport master (output mem_req_o, output mem_we_o, output iord_o, input mem_ready_i);
    modport slave  (input mem_req_o, input mem_we_o, input iord_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over a shared memory port.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP and raise illegal_o.
module multicycle_controller #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32,
    parameter int STATE_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          instr_i,
    input  logic                 zero_i,
    multicycle_controller_if.master mem,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic                 pc_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic [1:0]           shift_o,
    output logic                 reg_write_o,
    output logic [1:0]           result_src_o,
    output logic [STATE_W-1:0]   state_o,
    output logic [CNT_W-1:0]     instret_o,
    output logic                 illegal_o
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 0,
        S_DECODE   = 1,
        S_MEMADR   = 2,
        S_MEMREAD  = 3,
        S_MEMWB    = 4,
        S_MEMWRITE = 5,
        S_EXEC_R   = 6,
        S_EXEC_I   = 7,
        S_ALUWB    = 8,
        S_BRANCH   = 9,
        S_JUMP     = 10
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP   = 11
`endif
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             mem_req, mem_we, iord;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign funct7       = instr_i[31:25];
    assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = ALU_ADD;
        shift_o      = 2'b00;
        reg_write_o  = 1'b0;
        result_src_o = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b_o = 2'b10;
                if (mem.mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode)
                    7'h03, 7'h23: state_d = S_MEMADR;
                    7'h33:        state_d = S_EXEC_R;
                    7'h13:        state_d = S_EXEC_I;
                    7'h63:        state_d = S_BRANCH;
                    7'h6F, 7'h67: state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (opcode == 7'h03) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem.mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'b01;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem.mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'b10;
                if (funct7 != 7'h00)      alu_ctrl_o = ALU_SUB;
                else if (funct3 == 3'b000) alu_ctrl_o = ALU_ADD;
                else if (funct3 == 3'b111) alu_ctrl_o = ALU_AND;
                else                       alu_ctrl_o = ALU_OR;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (funct3 == 3'd1)      shift_o = 2'b11;
                else if (funct3 == 3'd5) shift_o = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_ctrl_o  = ALU_SUB;
                // Only beq/bne are resolved; other branch types fall through without a PC write.
                if ((funct3 == 3'b000 && zero_i) || (funct3 == 3'b001 && !zero_i)) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                alu_src_a_o  = (opcode == 7'h67) ? 2'b10 : 2'b01;
                alu_src_b_o  = 2'b01;
                reg_write_o  = 1'b1;
                result_src_o = 2'b10;
                pc_write_o   = 1'b1;
                pc_src_o     = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

        // Reset abandons any in-flight request, so every strobe is silenced for that cycle.
        if (rst_i) begin
            retire       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            iord         = 1'b0;
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            pc_src_o     = 1'b0;
            alu_src_a_o  = 2'b00;
            alu_src_b_o  = 2'b00;
            alu_ctrl_o   = '0;
            shift_o      = 2'b00;
            reg_write_o  = 1'b0;
            result_src_o = 2'b00;
        end
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk_i) begin
        if (rst_i) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    assign mem.mem_req_o = mem_req;
    assign mem.mem_we_o  = mem_we;
    assign mem.iord_o    = iord;
    assign state_o       = state_q;
    assign instret_o     = instret_q;

endmodule
